// File: rtl/rv32i_lsu_if.sv
// Execute-stage request, data-memory bus and write-back response bundle for the RV32I LSU.
// master is the LSU side; slave is the pipeline/memory environment side.
interface rv32i_lsu_if #(
   parameter int unsigned WIDTH = 32
);
   // execute-stage request
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [2:0]       req_funct3;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic [4:0]       req_rd;

   // data memory bus
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [3:0]       mem_be;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;

   // write-back response and error reporting
   logic             resp_valid;
   logic [4:0]       resp_rd;
   logic [WIDTH-1:0] resp_data;
   logic             st_done;
   logic             misalign_err;
   logic             bus_err;
   logic [WIDTH-1:0] err_addr;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      input  mem_ack, mem_rdata,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output resp_valid, resp_rd, resp_data, st_done,
      output misalign_err, bus_err, err_addr
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
      output mem_ack, mem_rdata,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  resp_valid, resp_rd, resp_data, st_done,
      input  misalign_err, bus_err, err_addr
   );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I memory-stage load/store unit: byte/half/word accesses over a word-organised
// req/ack data bus, with load extension, misalignment and bus-timeout reporting.
module rv32i_lsu #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic         clk,
   input logic         rst,
   rv32i_lsu_if.master bus
);
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      RESP,
      ERR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] addr_q;
   logic [2:0]       funct3_q;
   logic [4:0]       rd_q;

   logic             legal_c;
   logic             aligned_c;
   logic [WIDTH-1:0] wdata_c;
   logic [3:0]       be_c;
   logic [WIDTH-1:0] lane_c;
   logic [WIDTH-1:0] load_c;

   // request decode: funct3 legality depends on direction, alignment on access size
   always_comb begin
      legal_c   = 1'b0;
      aligned_c = 1'b1;
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: legal_c = 1'b1;
         3'b100, 3'b101:         legal_c = !bus.req_we;
         default:                legal_c = 1'b0;
      endcase
      case (bus.req_funct3[1:0])
         2'b01:   aligned_c = !bus.req_addr[0];
         2'b10:   aligned_c = (bus.req_addr[1:0] == 2'b00);
         default: aligned_c = 1'b1;
      endcase
   end

   // store lane replication and byte enables; loads always read the full word
   always_comb begin
      wdata_c = bus.req_wdata;
      be_c    = 4'b1111;
      if (bus.req_we) begin
         case (bus.req_funct3[1:0])
            2'b00: begin
               wdata_c = WIDTH'({4{bus.req_wdata[7:0]}});
               be_c    = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
               wdata_c = WIDTH'({2{bus.req_wdata[15:0]}});
               be_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               wdata_c = bus.req_wdata;
               be_c    = 4'b1111;
            end
         endcase
      end
   end

   // load lane extraction and extension from the word returned with mem_ack
   always_comb begin
      lane_c = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      load_c = lane_c;
      case (funct3_q)
         3'b000:  load_c = {{(WIDTH-8){lane_c[7]}}, lane_c[7:0]};
         3'b001:  load_c = {{(WIDTH-16){lane_c[15]}}, lane_c[15:0]};
         3'b100:  load_c = {{(WIDTH-8){1'b0}}, lane_c[7:0]};
         3'b101:  load_c = {{(WIDTH-16){1'b0}}, lane_c[15:0]};
         default: load_c = lane_c;
      endcase
   end

   // control FSM with registered outputs; pulses default low every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         addr_q           <= '0;
         funct3_q         <= '0;
         rd_q             <= '0;
         bus.req_ready    <= 1'b1;
         bus.mem_req      <= 1'b0;
         bus.mem_we       <= 1'b0;
         bus.mem_addr     <= '0;
         bus.mem_wdata    <= '0;
         bus.mem_be       <= '0;
         bus.resp_valid   <= 1'b0;
         bus.resp_rd      <= '0;
         bus.resp_data    <= '0;
         bus.st_done      <= 1'b0;
         bus.misalign_err <= 1'b0;
         bus.bus_err      <= 1'b0;
         bus.err_addr     <= '0;
      end else begin
         bus.resp_valid   <= 1'b0;
         bus.st_done      <= 1'b0;
         bus.misalign_err <= 1'b0;
         bus.bus_err      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q        <= bus.req_addr;
                  funct3_q      <= bus.req_funct3;
                  rd_q          <= bus.req_rd;
                  bus.req_ready <= 1'b0;
                  if (legal_c && aligned_c) begin
                     state         <= WAIT_ACK;
                     cnt           <= '0;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.req_we;
                     bus.mem_addr  <= {bus.req_addr[WIDTH-1:2], 2'b00};
                     bus.mem_wdata <= wdata_c;
                     bus.mem_be    <= be_c;
                  end else begin
                     state            <= ERR;
                     bus.misalign_err <= 1'b1;
                     bus.err_addr     <= bus.req_addr;
                  end
               end
            end
            WAIT_ACK: begin
               cnt <= cnt + CNT_W'(1);
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  if (bus.mem_we) begin
                     state         <= IDLE;
                     bus.st_done   <= 1'b1;
                     bus.req_ready <= 1'b1;
                  end else begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_data  <= load_c;
                     bus.resp_rd    <= rd_q;
                  end
               end else if (cnt == CNT_LAST) begin
                  state         <= IDLE;
                  bus.mem_req   <= 1'b0;
                  bus.bus_err   <= 1'b1;
                  bus.err_addr  <= addr_q;
                  bus.req_ready <= 1'b1;
               end
            end
            RESP, ERR: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
Load/store unit for the RV32I memory stage. Sits directly downstream of the ALU and upstream of the write-back mux. It takes the effective address from alu_out and store data from RS2, and performs byte, halfword and word accesses against a word-organised data memory using a req/ack handshake. Load data is sign- or zero-extended before it goes to write-back. Misalignment and bus timeouts are flagged.

Parameters:
WIDTH, 32, data and address width.
TIMEOUT, 16, maximum cycles in WAIT_ACK before a bus error; the legal range is 2 to 255.

Ports:
clk  in  1  clock.
rst  in  1  reset: synchronous, active-high.
req_valid  in  1  execute stage presents a memory operation.
req_ready  out  1  LSU can accept a request; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3 (access size and signedness).
req_addr  in  WIDTH  effective byte address from the ALU.
req_wdata  in  WIDTH  store data (RS2).
req_rd  in  5  destination register for loads.
mem_req  out  1  data memory request.
mem_we  out  1  data memory write enable.
mem_addr  out  WIDTH  word-aligned address; bits [1:0] are always 0.
mem_wdata  out  WIDTH  lane-replicated store data.
mem_be  out  4  byte enables.
mem_ack  in  1  memory completed the request; read data is valid in the same cycle.
mem_rdata  in  WIDTH  read word.
resp_valid  out  1  one-cycle pulse: load result is ready for write-back.
resp_rd  out  5  destination register of the load.
resp_data  out  WIDTH  extended load result.
st_done  out  1  one-cycle pulse: store completed.
misalign_err  out  1  one-cycle pulse: misaligned access or illegal funct3.
bus_err  out  1  one-cycle pulse: timeout waiting for mem_ack.
err_addr  out  WIDTH  req_addr of the faulting access; held until the next error.

Behaviour:
- Reset: state goes to IDLE and the timeout counter clears. Every output is 0 except req_ready, which is 1.
- States: IDLE, WAIT_ACK, RESP, ERR.
- IDLE: req_ready=1. The LSU accepts when req_valid=1 and registers addr, wdata, rd, we and funct3.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal and the request goes to ERR.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, goes to ERR.
  - Any legal, aligned request goes to WAIT_ACK.
- WAIT_ACK: mem_req=1. mem_addr, mem_we, mem_wdata and mem_be are held stable until ack. The counter increments every cycle.
  - mem_ack=1 on a load: capture the lane and go to RESP.
  - mem_ack=1 on a store: pulse st_done on the next cycle and go to IDLE.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req, pulse bus_err, load err_addr, go to IDLE.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_data and resp_rd hold their values until the next load response.
- ERR: misalign_err=1 and err_addr is loaded for one cycle, then IDLE. No memory access is issued.
- Store lanes:
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: mem_wdata = wdata, mem_be = 4'b1111.
- Load extraction: lane = mem_rdata >> (8*addr[1:0]).
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Loads use mem_be=4'b1111 and mem_we=0.
- Latency with ack in the first WAIT_ACK cycle:
  - Accept at cycle 0, mem_req high at cycle 1, ack at cycle 1.
  - Load: resp_valid at cycle 2. Store: st_done at cycle 2.
  - Next accept is possible at cycle 3 for a load and cycle 2 for a store.
- Loads with rd=0 still perform the access and pulse resp_valid with resp_rd=0.
- mem_ack outside WAIT_ACK is ignored.
- rst asserted mid-access drops mem_req at the next edge. No response or error pulse is produced for the aborted access.
- req_valid while req_ready=0 is ignored; the upstream stage holds its request.

Test Plan:
- Reset: assert rst for 2 cycles -> req_ready=1; mem_req, resp_valid, st_done, misalign_err and bus_err all 0; err_addr=0.
- LB and LBU: addr=0x103, mem_rdata=0x80AABBCC, ack after 3 cycles -> mem_addr=0x100, mem_be=4'b1111, mem_we=0. LB gives resp_data=0xFFFFFF80; LBU gives 0x00000080. resp_valid is high for 1 cycle, with resp_rd matching the request.
- SH: addr=0x22, wdata=0x1234ABCD, ack in the first cycle -> mem_addr=0x20, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1; st_done pulses on the following cycle.
- LW misaligned: addr=0x41 -> no mem_req; misalign_err=1 for one cycle; err_addr=0x41. Repeat with funct3=3'b011 -> same error response.
- Timeout: LW to 0x80 with mem_ack held at 0 -> mem_req high for exactly TIMEOUT cycles, then bus_err pulses with err_addr=0x80, and req_ready=1 on the following cycle.
- Back-to-back and reset: SW to 0x10 immediately followed by LHU to 0x12 with mem_rdata=0xBEEF0000 -> mem_be=4'b1111 for the SW, then resp_data=0x0000BEEF. A separate run asserts rst while in WAIT_ACK -> mem_req=0 after the next edge and no resp_valid.
